ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage consuming the ID/EX pipeline register bundle (ALU op, rd, src1, src2-or-immediate) and producing a registered EX/MEM result bundle. Single-cycle ALU ops complete in one clock; multiply and divide run on an iterative radix-2 datapath. While an iterative op runs, the stage drives `stall` upstream so the ID/EX register and earlier stages hold.

## Interface
- `XLEN`, 32: operand and result width; equals `` `COMMON_WIDTH ``.
- `ITER`, 32: iterations per mul/div; equals `XLEN`.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  ID/EX bundle valid this cycle.
- `alu_type`  in  `` `ALU_TYPE_WIDTH ``  operation code.
- `src1`  in  `XLEN`  operand A.
- `src2_imm`  in  `XLEN`  operand B, already immediate-muxed.
- `rd`  in  `` `REG_NUM ``  destination register.
- `stall`  out  1  high while an iterative op is in flight; upstream must hold its bundle.
- `out_valid`  out  1  result bundle valid, one-cycle pulse per op.
- `out_rd`  out  `` `REG_NUM ``  destination register of the result.
- `out_result`  out  `XLEN`  result.

## Operation
- Accept on a rising edge where `in_valid && !stall`. When `stall` is high, inputs are ignored.
- FSM states: IDLE, MUL, DIV. `stall = (state != IDLE)`.
- **Single-cycle ops** (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU):
  - Result registered at the accept edge; `out_valid=1` for the following cycle.
  - Shifts use `src2_imm[4:0]`.
  - SLT and SLTU write 0 or 1.
- **MUL, MULH, MULHU**:
  - IDLE→MUL on accept.
  - Operands are latched as magnitudes, with a latched sign-fix flag (MULH only).
  - One shift-add per cycle into a 64-bit accumulator.
  - After `ITER` iterations: apply the sign fix, select the low word (MUL) or high word, then return to IDLE.
- **DIV, DIVU, REM, REMU**:
  - IDLE→DIV on accept.
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Signed fixup: quotient negative if operand signs differ; remainder takes the sign of the dividend.
- **Divide-by-zero:** quotient = 0xFFFFFFFF; remainder = dividend. Same latency as a normal divide.
- **Signed overflow** (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- **Unknown `alu_type`:** single-cycle, result 0, `out_valid=1`.
- `out_valid` is low in every cycle without a completing op. `out_rd` and `out_result` hold their last value when `out_valid` is low.
- **Reset** (including mid-operation): state=IDLE, iteration counter=0, `stall=0`, `out_valid=0`, `out_rd=0`, `out_result=0`. The in-flight op is discarded.

## Timing
- Single-cycle ops:
  - Accept at edge N → `out_valid` high in cycle N+1.
  - Back-to-back accepts every cycle.
- Iterative ops:
  - Accept at edge N → `stall` high in cycles N+1 … N+ITER.
  - The result is written at edge N+ITER.
  - `out_valid` is high and `stall` is low in cycle N+ITER+1; the next accept can occur at edge N+ITER+1.
- There are no simultaneous accept/complete conflicts: accept requires `!stall`, and completion occurs only while stalled.
- The counter is `$clog2(ITER)+1` bits and counts 0…ITER-1. Wrap is not possible because the FSM leaves MUL/DIV at ITER-1.

## Configuration
- `EX_MULDIV_EN` defined:
  - MUL/DIV states and the iterative datapath are compiled in.
  - Behaviour is as above.
- `EX_MULDIV_EN` undefined:
  - The FSM is reduced to IDLE and `stall` is tied to 0.
  - All mul/div opcodes are treated as unknown: single-cycle, result 0.

## Structure
- Shared `define.h` holds:
  - `` `COMMON_WIDTH ``, `` `REG_NUM ``, `` `ALU_TYPE_WIDTH ``;
  - all `ALU_*` opcode constants, including the new MUL/MULH/MULHU/DIV/DIVU/REM/REMU codes;
  - FSM state encodings `EX_ST_IDLE`, `EX_ST_MUL`, `EX_ST_DIV`.
- Natural sub-module: `ex_muldiv_iter`. It holds the iterative shift-add / restoring-divide datapath with start/done, instantiated only under `EX_MULDIV_EN`. `ex_stage` keeps the single-cycle ALU, FSM and output register.

## Test plan
- ADD 5 + 0xFFFFFFFF, rd=3 → next cycle `out_valid=1`, `out_rd=3`, `out_result=4`. Back-to-back SUB 1−2 → 0xFFFFFFFF in the following cycle.
- MULH 0xFFFFFFFE × 3 → `stall` high exactly 32 cycles; then `out_result=0xFFFFFFFF`, `out_valid` pulse of one cycle. An `in_valid` ADD held during the stall executes once afterwards.
- DIV −7 / 2 → quotient 0xFFFFFFFD. REM −7 / 2 → 0xFFFFFFFF. DIVU 7 / 0 → 0xFFFFFFFF. REM 7 / 0 → 7.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- Assert `rst` at iteration 10 of a DIV → `stall`, `out_valid`, `out_result` all 0 immediately. After release, ADD 1+1 → 2 next cycle.
- Build without `EX_MULDIV_EN`: MUL 3×3 → `stall` never high; next-cycle `out_valid=1`, `out_result=0`.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared widths, ALU opcodes, execute-stage FSM states and
// opcode-class helpers for the execute stage and its iterative mul/div unit.
package ex_stage_pkg;

    localparam int COMMON_WIDTH   = 32;
    localparam int REG_NUM        = 5;
    localparam int ALU_TYPE_WIDTH = 5;

    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_ADD   = 5'd0;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_SUB   = 5'd1;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_AND   = 5'd2;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_OR    = 5'd3;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_XOR   = 5'd4;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_SLL   = 5'd5;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_SRL   = 5'd6;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_SRA   = 5'd7;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_SLT   = 5'd8;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_SLTU  = 5'd9;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_MUL   = 5'd10;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_MULH  = 5'd11;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_MULHU = 5'd12;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_DIV   = 5'd13;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_DIVU  = 5'd14;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_REM   = 5'd15;
    localparam logic [ALU_TYPE_WIDTH-1:0] ALU_REMU  = 5'd16;

    typedef enum logic [1:0] {
        EX_ST_IDLE = 2'd0,
        EX_ST_MUL  = 2'd1,
        EX_ST_DIV  = 2'd2
    } ex_state_e;

    function automatic logic is_mul_op(input logic [ALU_TYPE_WIDTH-1:0] op);
        return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHU);
    endfunction

    function automatic logic is_div_op(input logic [ALU_TYPE_WIDTH-1:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// ex_muldiv_iter: iterative radix-2 datapath for MUL/MULH/MULHU (shift-add into
// a 2*XLEN accumulator) and DIV/DIVU/REM/REMU (restoring division on magnitudes).
// Sequencing (iteration count, completion) is owned by the instantiating FSM.
// Ports:
//   clk       clock, rising edge
//   i_start   latch operands and op on this edge
//   i_busy    perform one iteration on this edge
//   i_op      ALU opcode of the op being started
//   i_src1/2  operands A and B
//   o_result  final result, valid during the cycle whose edge performs the
//             last iteration (computed from that iteration's next state)
module ex_muldiv_iter
    import ex_stage_pkg::*;
#(
    parameter int XLEN = COMMON_WIDTH
) (
    input  logic                      clk,
    input  logic                      i_start,
    input  logic                      i_busy,
    input  logic [ALU_TYPE_WIDTH-1:0] i_op,
    input  logic [XLEN-1:0]           i_src1,
    input  logic [XLEN-1:0]           i_src2,
    output logic [XLEN-1:0]           o_result
);

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic en);
        return (en && x[XLEN-1]) ? (~x + 1'b1) : x;
    endfunction

    logic [2*XLEN-1:0] r_acc, r_mcand, w_acc_nxt, w_prod;
    logic [XLEN-1:0]   r_mplier, r_rem, r_quo, r_dvsr;
    logic [XLEN-1:0]   w_rem_nxt, w_quo_nxt, w_quo_fix, w_rem_fix, w_mag1, w_mag2;
    logic [XLEN:0]     w_part, w_diff;
    logic              w_ge, w_mul_signed, w_div_signed;
    logic              r_neg_p, r_neg_q, r_neg_r, r_sel_hi, r_sel_rem, r_is_div;

    // Only MULH needs signed magnitudes: the low word is sign-agnostic.
    assign w_mul_signed = (i_op == ALU_MULH);
    assign w_div_signed = (i_op == ALU_DIV) || (i_op == ALU_REM);
    assign w_mag1       = mag(i_src1, w_mul_signed || w_div_signed);
    assign w_mag2       = mag(i_src2, w_mul_signed || w_div_signed);

    // Shift-add step.
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Restoring-divide step: bring in the next dividend bit, try a subtract.
    assign w_part    = {r_rem, r_quo[XLEN-1]};
    assign w_diff    = w_part - {1'b0, r_dvsr};
    assign w_ge      = !w_diff[XLEN];
    assign w_rem_nxt = w_ge ? w_diff[XLEN-1:0] : w_part[XLEN-1:0];
    assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};

    // Divide-by-zero yields an all-ones magnitude quotient and the dividend
    // magnitude as remainder; suppressing quotient negation keeps 0xFFFFFFFF.
    assign w_prod    = r_neg_p ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
    assign w_quo_fix = r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
    assign w_rem_fix = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;

    assign o_result = r_is_div ? (r_sel_rem ? w_rem_fix : w_quo_fix)
                               : (r_sel_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0]);

    always_ff @(posedge clk) begin
        if (i_start) begin
            r_acc     <= '0;
            r_mcand   <= {{XLEN{1'b0}}, w_mag1};
            r_mplier  <= w_mag2;
            r_rem     <= '0;
            r_quo     <= w_mag1;
            r_dvsr    <= w_mag2;
            r_neg_p   <= w_mul_signed && (i_src1[XLEN-1] ^ i_src2[XLEN-1]);
            r_neg_q   <= w_div_signed && (i_src1[XLEN-1] ^ i_src2[XLEN-1]) && (i_src2 != '0);
            r_neg_r   <= w_div_signed && i_src1[XLEN-1];
            r_sel_hi  <= (i_op != ALU_MUL);
            r_sel_rem <= (i_op == ALU_REM) || (i_op == ALU_REMU);
            r_is_div  <= is_div_op(i_op);
        end else if (i_busy) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_rem    <= w_rem_nxt;
            r_quo    <= w_quo_nxt;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage. Consumes the ID/EX bundle, runs single-cycle ALU ops
// directly into the EX/MEM output register, and sequences iterative mul/div
// through ex_muldiv_iter while holding upstream with stall.
// Build option: EX_MULDIV_EN -- when defined, MUL/DIV FSM states and the
// iterative datapath are present; when undefined, mul/div opcodes behave as
// unknown ops (single cycle, result 0) and stall is tied low.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid            ID/EX bundle valid
//   alu_type            opcode
//   src1, src2_imm      operands (B already immediate-muxed)
//   rd                  destination register
//   stall               iterative op in flight, upstream holds
//   out_valid           one-cycle pulse per completed op
//   out_rd, out_result  registered result bundle, held while out_valid is low
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int XLEN = COMMON_WIDTH,
    parameter int ITER = XLEN
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [ALU_TYPE_WIDTH-1:0] alu_type,
    input  logic [XLEN-1:0]           src1,
    input  logic [XLEN-1:0]           src2_imm,
    input  logic [REG_NUM-1:0]        rd,
    output logic                      stall,
    output logic                      out_valid,
    output logic [REG_NUM-1:0]        out_rd,
    output logic [XLEN-1:0]           out_result
);

    function automatic logic [XLEN-1:0] alu_single(input logic [ALU_TYPE_WIDTH-1:0] op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        logic [4:0] shamt;
        shamt = b[4:0];
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << shamt;
            ALU_SRL:  return a >> shamt;
            ALU_SRA:  return $unsigned($signed(a) >>> shamt);
            ALU_SLT:  return {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: return {{(XLEN-1){1'b0}}, (a < b)};
            default:  return '0;
        endcase
    endfunction

    logic               w_accept, w_is_md, w_md_done;
    logic [XLEN-1:0]    w_alu_result, w_md_result;
    logic [REG_NUM-1:0] w_md_rd;

    assign w_accept     = in_valid && !stall;
    assign w_alu_result = alu_single(alu_type, src1, src2_imm);

`ifdef EX_MULDIV_EN
    localparam int CNT_W = $clog2(ITER) + 1;

    ex_state_e          r_state, w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [REG_NUM-1:0] r_md_rd;
    logic               w_last;

    assign w_is_md   = is_mul_op(alu_type) || is_div_op(alu_type);
    assign w_last    = (r_cnt == CNT_W'(ITER - 1));
    assign stall     = (r_state != EX_ST_IDLE);
    assign w_md_done = stall && w_last;
    assign w_md_rd   = r_md_rd;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            EX_ST_IDLE: begin
                if (w_accept && is_mul_op(alu_type))
                    w_state_next = EX_ST_MUL;
                else if (w_accept && is_div_op(alu_type))
                    w_state_next = EX_ST_DIV;
            end
            EX_ST_MUL, EX_ST_DIV: begin
                if (w_last)
                    w_state_next = EX_ST_IDLE;
            end
            default: w_state_next = EX_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EX_ST_IDLE;
            r_cnt   <= '0;
            r_md_rd <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == EX_ST_IDLE)
                r_cnt <= '0;
            else
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (w_accept && w_is_md)
                r_md_rd <= rd;
        end
    end

    ex_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk      (clk),
        .i_start  (w_accept && w_is_md),
        .i_busy   (stall),
        .i_op     (alu_type),
        .i_src1   (src1),
        .i_src2   (src2_imm),
        .o_result (w_md_result)
    );
`else
    assign stall       = 1'b0;
    assign w_is_md     = 1'b0;
    assign w_md_done   = 1'b0;
    assign w_md_result = '0;
    assign w_md_rd     = '0;
`endif

    // Completion of an iterative op and a new single-cycle accept are mutually
    // exclusive because accepts require stall low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_rd     <= '0;
            out_result <= '0;
        end else if (w_md_done) begin
            out_valid  <= 1'b1;
            out_rd     <= w_md_rd;
            out_result <= w_md_result;
        end else if (w_accept && !w_is_md) begin
            out_valid  <= 1'b1;
            out_rd     <= rd;
            out_result <= w_alu_result;
        end else begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
`timescale 1ns/1ps
module tb_ex_stage;
    import ex_stage_pkg::*;

`ifdef EX_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif
    localparam int ITER = 32;

    logic        clk = 1'b0;
    logic        rst, in_valid;
    logic [4:0]  alu_type, rd, out_rd;
    logic [31:0] src1, src2_imm, out_result;
    logic        stall, out_valid;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .alu_type   (alu_type),
        .src1       (src1),
        .src2_imm   (src2_imm),
        .rd         (rd),
        .stall      (stall),
        .out_valid  (out_valid),
        .out_rd     (out_rd),
        .out_result (out_result)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  r;
        logic [31:0] exp;
        bit          md;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic bit is_md(input logic [4:0] op);
        return (op >= ALU_MUL) && (op <= ALU_REMU);
    endfunction

    // Reference: results straight from the arithmetic definitions.
    function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic signed [63:0] sp;
        logic [63:0]        up;
        bit                 ovf;
        sa  = a;
        sb  = b;
        sp  = 64'(sa) * 64'(sb);
        up  = {32'd0, a} * {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (is_md(op) && !MD_EN) return 32'd0;
        case (op)
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_AND:   return a & b;
            ALU_OR:    return a | b;
            ALU_XOR:   return a ^ b;
            ALU_SLL:   return a << b[4:0];
            ALU_SRL:   return a >> b[4:0];
            ALU_SRA:   return $unsigned(sa >>> b[4:0]);
            ALU_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            ALU_MUL:   return up[31:0];
            ALU_MULH:  return sp[63:32];
            ALU_MULHU: return up[63:32];
            ALU_DIV:   return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : $unsigned(sa / sb);
            ALU_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REM:   return (b == 0) ? a : ovf ? 32'd0 : $unsigned(sa % sb);
            ALU_REMU:  return (b == 0) ? a : a % b;
            default:   return 32'd0;
        endcase
    endfunction

    task automatic add_vec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] r, input logic [31:0] exp, input bit md);
        vecs.push_back('{op, a, b, r, exp, md});
    endtask

    // One op with in_valid for a single accept edge; checks stall length,
    // no stray out_valid while stalled, then the result bundle.
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input logic [31:0] exp, input string name);
        int n_stall = 0;
        int bad_vld = 0;
        in_valid = 1'b1; alu_type = op; src1 = a; src2_imm = b; rd = r;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (stall && n_stall < 100) begin
            if (out_valid) bad_vld++;
            @(posedge clk); #1;
            n_stall++;
        end
        check({name, " stall_cycles"}, 32'(n_stall), 32'((MD_EN && is_md(op)) ? ITER : 0));
        check({name, " vld_during_stall"}, 32'(bad_vld), 32'd0);
        check({name, " out_valid"}, {31'd0, out_valid}, 32'd1);
        check({name, " out_rd"}, {27'd0, out_rd}, {27'd0, r});
        check({name, " out_result"}, out_result, exp);
    endtask

    initial begin
        logic [4:0]  op, r;
        logic [31:0] a, b;
        int          n, bad;

        rst = 1'b1; in_valid = 1'b0; alu_type = '0; src1 = '0; src2_imm = '0; rd = '0;

        add_vec(ALU_ADD,   32'd5,         32'hFFFF_FFFF, 5'd3,  32'd4,         1'b0);
        add_vec(ALU_SUB,   32'd1,         32'd2,         5'd4,  32'hFFFF_FFFF, 1'b0);
        add_vec(ALU_AND,   32'hF0F0_F0F0, 32'hFF00_FF00, 5'd5,  32'hF000_F000, 1'b0);
        add_vec(ALU_OR,    32'hF0F0_F0F0, 32'hFF00_FF00, 5'd6,  32'hFFF0_FFF0, 1'b0);
        add_vec(ALU_XOR,   32'hF0F0_F0F0, 32'hFF00_FF00, 5'd7,  32'h0FF0_0FF0, 1'b0);
        add_vec(ALU_SLL,   32'd1,         32'd31,        5'd8,  32'h8000_0000, 1'b0);
        add_vec(ALU_SLL,   32'd3,         32'h21,        5'd9,  32'd6,         1'b0);
        add_vec(ALU_SRL,   32'h8000_0000, 32'd4,         5'd10, 32'h0800_0000, 1'b0);
        add_vec(ALU_SRA,   32'h8000_0000, 32'd4,         5'd11, 32'hF800_0000, 1'b0);
        add_vec(ALU_SLT,   32'hFFFF_FFFF, 32'd1,         5'd12, 32'd1,         1'b0);
        add_vec(ALU_SLTU,  32'hFFFF_FFFF, 32'd1,         5'd13, 32'd0,         1'b0);
        add_vec(5'd31,     32'd7,         32'd9,         5'd14, 32'd0,         1'b0);
        add_vec(ALU_MULH,  32'hFFFF_FFFE, 32'd3,         5'd15, 32'hFFFF_FFFF, 1'b1);
        add_vec(ALU_MUL,   32'd3,         32'd3,         5'd16, 32'd9,         1'b1);
        add_vec(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'hFFFF_FFFE, 1'b1);
        add_vec(ALU_DIV,   32'hFFFF_FFF9, 32'd2,         5'd18, 32'hFFFF_FFFD, 1'b1);
        add_vec(ALU_REM,   32'hFFFF_FFF9, 32'd2,         5'd19, 32'hFFFF_FFFF, 1'b1);
        add_vec(ALU_DIVU,  32'd7,         32'd0,         5'd20, 32'hFFFF_FFFF, 1'b1);
        add_vec(ALU_REM,   32'd7,         32'd0,         5'd21, 32'd7,         1'b1);
        add_vec(ALU_DIV,   32'hFFFF_FFF8, 32'd0,         5'd22, 32'hFFFF_FFFF, 1'b1);
        add_vec(ALU_REM,   32'hFFFF_FFF8, 32'd0,         5'd23, 32'hFFFF_FFF8, 1'b1);
        add_vec(ALU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 5'd24, 32'h8000_0000, 1'b1);
        add_vec(ALU_REM,   32'h8000_0000, 32'hFFFF_FFFF, 5'd25, 32'd0,         1'b1);
        add_vec(ALU_DIVU,  32'd100,       32'd7,         5'd26, 32'd14,        1'b1);
        add_vec(ALU_REMU,  32'd100,       32'd7,         5'd27, 32'd2,         1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("reset stall", {31'd0, stall}, 32'd0);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_rd", {27'd0, out_rd}, 32'd0);
        check("reset out_result", out_result, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle out_valid", {31'd0, out_valid}, 32'd0);

        foreach (vecs[i])
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r,
                  (vecs[i].md && !MD_EN) ? 32'd0 : vecs[i].exp, $sformatf("vec%0d", i));

        // Back-to-back single-cycle accepts, then the output holds.
        in_valid = 1'b1; alu_type = ALU_ADD; src1 = 32'd5; src2_imm = 32'hFFFF_FFFF; rd = 5'd3;
        @(posedge clk); #1;
        alu_type = ALU_SUB; src1 = 32'd1; src2_imm = 32'd2; rd = 5'd4;
        check("b2b add out_valid", {31'd0, out_valid}, 32'd1);
        check("b2b add out_rd", {27'd0, out_rd}, 32'd3);
        check("b2b add out_result", out_result, 32'd4);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b sub out_valid", {31'd0, out_valid}, 32'd1);
        check("b2b sub out_rd", {27'd0, out_rd}, 32'd4);
        check("b2b sub out_result", out_result, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        check("b2b pulse end", {31'd0, out_valid}, 32'd0);
        check("b2b hold result", out_result, 32'hFFFF_FFFF);
        check("b2b hold rd", {27'd0, out_rd}, 32'd4);

        // MULH with an ADD held on in_valid throughout the stall.
        in_valid = 1'b1; alu_type = ALU_MULH; src1 = 32'hFFFF_FFFE; src2_imm = 32'd3; rd = 5'd9;
        @(posedge clk); #1;
        alu_type = ALU_ADD; src1 = 32'd10; src2_imm = 32'd20; rd = 5'd10;
        n = 0; bad = 0;
        while (stall && n < 100) begin
            if (out_valid) bad++;
            @(posedge clk); #1;
            n++;
        end
        check("held stall_cycles", 32'(n), 32'(MD_EN ? ITER : 0));
        check("held vld_during_stall", 32'(bad), 32'd0);
        check("held mulh out_valid", {31'd0, out_valid}, 32'd1);
        check("held mulh out_rd", {27'd0, out_rd}, 32'd9);
        check("held mulh out_result", out_result, MD_EN ? 32'hFFFF_FFFF : 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("held add out_valid", {31'd0, out_valid}, 32'd1);
        check("held add out_rd", {27'd0, out_rd}, 32'd10);
        check("held add out_result", out_result, 32'd30);
        @(posedge clk); #1;
        check("held add once", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a divide.
        in_valid = 1'b1; alu_type = ALU_DIV; src1 = 32'hFFFF_FFF9; src2_imm = 32'd2; rd = 5'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid-div stall", {31'd0, stall}, {31'd0, MD_EN});
        rst = 1'b1;
        #1;
        check("async rst stall", {31'd0, stall}, 32'd0);
        check("async rst out_valid", {31'd0, out_valid}, 32'd0);
        check("async rst out_result", out_result, 32'd0);
        check("async rst out_rd", {27'd0, out_rd}, 32'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check("post rst stall", {31'd0, stall}, 32'd0);
        check("post rst out_valid", {31'd0, out_valid}, 32'd0);
        do_op(ALU_ADD, 32'd1, 32'd1, 5'd1, 32'd2, "post rst add");

        // Randomized ops against the reference model.
        for (int i = 0; i < 120; i++) begin
            n  = $urandom_range(0, 19);
            op = (n < 17) ? 5'(n) : 5'($urandom_range(17, 31));
            case ($urandom_range(0, 7))
                0: a = 32'd0;
                1: a = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: a = $urandom_range(0, 15);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'h8000_0000;
                3: b = $urandom_range(0, 15);
                default: b = $urandom;
            endcase
            r = 5'($urandom_range(0, 31));
            do_op(op, a, b, r, ref_model(op, a, b), $sformatf("rand%0d op%0d", i, op));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
